// File: rtl/uart_tx_port.sv
// Purpose     : CPU-mapped 8N1 serial transmitter with bit-7 strip and CR->CR LF expansion.
// Latency     : write at cycle N -> hold_full at N+1 -> start bit on uart_tx from N+2 (idle, CTS ready).
// Backpressure: one-byte hold register; writes while hold is full (and not draining) are dropped; CTS gates frame start.
//
// Ports:
//   clk14    14 MHz master clock
//   rst      synchronous reset, active high
//   enable   one-cycle access strobe (chip select qualified by cpu_clken)
//   w_en     write strobe, valid with enable
//   address  register select: 0 = data/busy, 1 = status
//   din      CPU write data
//   dout     CPU read data: addr0 {hold_full,7'b0}, addr1 {5'b0,cts_ok,tx_active,hold_full}
//   cts_n    host ready-to-receive, active low, asynchronous
//   uart_tx  serial line, registered, idle high
module uart_tx_port #(
    parameter int CLK_FREQ   = 14000000,
    parameter int BAUD       = 115200,
    parameter int DIVISOR    = (CLK_FREQ + BAUD / 2) / BAUD,
    parameter int STRIP_BIT7 = 1,
    parameter int CRLF       = 1
) (
    input  logic       clk14,
    input  logic       rst,
    input  logic       enable,
    input  logic       w_en,
    input  logic       address,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       cts_n,
    output logic       uart_tx
);

    localparam int            CW        = $clog2(DIVISOR + 1);
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIVISOR - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] baud_cnt, baud_cnt_nxt;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic [7:0]    shift, shift_nxt;
    logic          lf_pending, lf_pending_nxt;
    logic          tx_nxt;
    logic          take_hold;
    logic          baud_done;

    logic [7:0]    hold;
    logic          hold_full;
    logic [7:0]    mapped;
    logic          wr_data;
    logic          wr_accept;

    logic          cts_meta, cts_sync;
    logic          cts_ok;
    logic          tx_active;

    assign cts_ok    = ~cts_sync;
    assign tx_active = (state != IDLE);
    assign baud_done = (baud_cnt == BAUD_LAST);

    assign mapped    = (STRIP_BIT7 != 0) ? {1'b0, din[6:0]} : din;
    assign wr_data   = enable & w_en & ~address;
    // A write landing in the same cycle the hold drains into the shifter refills it.
    assign wr_accept = wr_data & (~hold_full | take_hold);

    always_comb begin
        dout = 8'h00;
        if (address == 1'b0) begin
            dout = {hold_full, 7'b0};
        end else begin
            dout = {5'b0, cts_ok, tx_active, hold_full};
        end
    end

    // Next-state and next-output logic. uart_tx is registered, so tx_nxt is the
    // line level for the state being entered, not the current one.
    always_comb begin
        state_nxt      = state;
        baud_cnt_nxt   = baud_cnt + 1'b1;
        bit_cnt_nxt    = bit_cnt;
        shift_nxt      = shift;
        lf_pending_nxt = lf_pending;
        tx_nxt         = uart_tx;
        take_hold      = 1'b0;

        case (state)
            IDLE: begin
                baud_cnt_nxt = '0;
                bit_cnt_nxt  = '0;
                tx_nxt       = 1'b1;
                // Pending LF goes ahead of the hold so CR LF stays adjacent.
                if (cts_ok && lf_pending) begin
                    shift_nxt      = 8'h0A;
                    lf_pending_nxt = 1'b0;
                    state_nxt      = START;
                    tx_nxt         = 1'b0;
                end else if (cts_ok && hold_full) begin
                    shift_nxt      = hold;
                    take_hold      = 1'b1;
                    lf_pending_nxt = (CRLF != 0) && (hold == 8'h0D);
                    state_nxt      = START;
                    tx_nxt         = 1'b0;
                end
            end
            START: begin
                if (baud_done) begin
                    state_nxt    = DATA;
                    baud_cnt_nxt = '0;
                    bit_cnt_nxt  = '0;
                    tx_nxt       = shift[0];
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_cnt_nxt = '0;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        shift_nxt   = {1'b0, shift[7:1]};
                        tx_nxt      = shift[1];
                    end
                end
            end
            STOP: begin
                tx_nxt = 1'b1;
                if (baud_done) begin
                    state_nxt    = IDLE;
                    baud_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt    = IDLE;
                baud_cnt_nxt = '0;
                tx_nxt       = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk14) begin
        if (rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            lf_pending <= 1'b0;
            uart_tx    <= 1'b1;
            hold       <= '0;
            hold_full  <= 1'b0;
            // Synchroniser resets to "not ready" so nothing starts until CTS is seen.
            cts_meta   <= 1'b1;
            cts_sync   <= 1'b1;
        end else begin
            state      <= state_nxt;
            baud_cnt   <= baud_cnt_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shift      <= shift_nxt;
            lf_pending <= lf_pending_nxt;
            uart_tx    <= tx_nxt;
            cts_meta   <= cts_n;
            cts_sync   <= cts_meta;
            if (wr_accept) begin
                hold      <= mapped;
                hold_full <= 1'b1;
            end else if (take_hold) begin
                hold_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_port.sv
// Purpose     : directed bench for uart_tx_port (reset, framing, CR LF, buffering, CTS, mid-frame reset).
// Latency     : inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: CTS driven directly by the bench; every wait is cycle-bounded.
module tb_uart_tx_port;

    logic       clk14   = 1'b0;
    logic       rst     = 1'b1;
    logic       enable  = 1'b0;
    logic       w_en    = 1'b0;
    logic       address = 1'b0;
    logic [7:0] din     = 8'h00;
    logic [7:0] dout;
    logic       cts_n   = 1'b1;
    logic       uart_tx;

    int tests = 0;
    int fails = 0;

    always #5 clk14 = ~clk14;

    uart_tx_port dut (
        .clk14   (clk14),
        .rst     (rst),
        .enable  (enable),
        .w_en    (w_en),
        .address (address),
        .din     (din),
        .dout    (dout),
        .cts_n   (cts_n),
        .uart_tx (uart_tx)
    );

    task automatic tick();
        @(posedge clk14);
        #1;
    endtask

    task automatic read_reg(input logic a, output logic [7:0] d);
        address = a;
        #1;
        d = dout;
    endtask

    task automatic do_write(input logic [7:0] d);
        enable  = 1'b1;
        w_en    = 1'b1;
        address = 1'b0;
        din     = d;
        tick();
        enable  = 1'b0;
        w_en    = 1'b0;
        din     = 8'h00;
    endtask

    // Records one 10-bit frame starting on the current (start-bit) cycle, taking
    // the first sample of each 122-cycle bit and counting any change inside a bit.
    task automatic capture(output logic [9:0] frame, output int unstable);
        logic v;
        frame    = '0;
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            v        = uart_tx;
            frame[i] = v;
            for (int c = 0; c < 122; c++) begin
                if (uart_tx !== v) unstable++;
                tick();
            end
        end
    endtask

    task automatic count_lows(input int cycles, output int lows);
        lows = 0;
        for (int c = 0; c < cycles; c++) begin
            tick();
            if (uart_tx !== 1'b1) lows++;
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        rst   = 1'b1;
        cts_n = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tests++;
        if (uart_tx !== 1'b1) begin fails++; $display("FAIL reset_line: got %b, expected 1", uart_tx); end
        read_reg(1'b0, d);
        tests++;
        if (d !== 8'h00) begin fails++; $display("FAIL reset_addr0: got %h, expected 00", d); end
        read_reg(1'b1, d);
        tests++;
        if (d !== 8'h00) begin fails++; $display("FAIL reset_addr1: got %h, expected 00", d); end
        cts_n = 1'b0;
        tick();
        tick();
        read_reg(1'b1, d);
        tests++;
        if (d !== 8'h04) begin fails++; $display("FAIL reset_cts_ok: got %h, expected 04", d); end
    endtask

    task automatic test_single();
        logic [7:0] d;
        logic [9:0] f;
        int         u;
        do_write(8'hC1);
        read_reg(1'b0, d);
        tests++;
        if (d !== 8'h80 || uart_tx !== 1'b1) begin
            fails++; $display("FAIL single_hold_n1: got addr0=%h line=%b, expected 80 1", d, uart_tx);
        end
        tick();
        read_reg(1'b0, d);
        tests++;
        if (d !== 8'h00 || uart_tx !== 1'b0) begin
            fails++; $display("FAIL single_start_n2: got addr0=%h line=%b, expected 00 0", d, uart_tx);
        end
        read_reg(1'b1, d);
        tests++;
        if (d !== 8'h06) begin fails++; $display("FAIL single_active: got %h, expected 06", d); end
        capture(f, u);
        tests++;
        if (f !== 10'b1_0100_0001_0 || u != 0) begin
            fails++; $display("FAIL single_frame: got %b unstable=%0d, expected 1010000010 unstable=0", f, u);
        end
        read_reg(1'b1, d);
        tests++;
        if (d !== 8'h04) begin fails++; $display("FAIL single_active_falls: got %h, expected 04", d); end
    endtask

    task automatic test_crlf();
        logic [7:0] d;
        logic [9:0] f;
        int         u, lows;
        do_write(8'h8D);
        tick();
        tests++;
        if (uart_tx !== 1'b0) begin fails++; $display("FAIL crlf_start: got %b, expected 0", uart_tx); end
        capture(f, u);
        tests++;
        if (f !== 10'b1_0000_1101_0 || u != 0) begin
            fails++; $display("FAIL crlf_cr_frame: got %b unstable=%0d, expected 1000011010 unstable=0", f, u);
        end
        read_reg(1'b1, d);
        tests++;
        if (uart_tx !== 1'b1 || d !== 8'h04) begin
            fails++; $display("FAIL crlf_gap: got line=%b addr1=%h, expected 1 04", uart_tx, d);
        end
        tick();
        tests++;
        if (uart_tx !== 1'b0) begin fails++; $display("FAIL crlf_lf_start: got %b, expected 0", uart_tx); end
        capture(f, u);
        tests++;
        if (f !== 10'b1_0000_1010_0 || u != 0) begin
            fails++; $display("FAIL crlf_lf_frame: got %b unstable=%0d, expected 1000010100 unstable=0", f, u);
        end
        count_lows(300, lows);
        tests++;
        if (lows != 0) begin fails++; $display("FAIL crlf_no_extra: got %0d low cycles, expected 0", lows); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        logic [9:0] f1, f2;
        int         u1, u2, lows;
        do_write(8'hB1);
        tick();
        tests++;
        if (uart_tx !== 1'b0) begin fails++; $display("FAIL buf_start1: got %b, expected 0", uart_tx); end
        fork
            capture(f1, u1);
            begin
                do_write(8'hB2);
                do_write(8'hB3);
                read_reg(1'b0, d);
                tests++;
                if (d !== 8'h80) begin fails++; $display("FAIL buf_full_during: got %h, expected 80", d); end
            end
        join
        tests++;
        if (f1 !== 10'b1_0011_0001_0 || u1 != 0) begin
            fails++; $display("FAIL buf_frame1: got %b unstable=%0d, expected 1001100010 unstable=0", f1, u1);
        end
        read_reg(1'b0, d);
        tests++;
        if (d !== 8'h80 || uart_tx !== 1'b1) begin
            fails++; $display("FAIL buf_gap: got addr0=%h line=%b, expected 80 1", d, uart_tx);
        end
        tick();
        read_reg(1'b0, d);
        tests++;
        if (d !== 8'h00 || uart_tx !== 1'b0) begin
            fails++; $display("FAIL buf_start2: got addr0=%h line=%b, expected 00 0", d, uart_tx);
        end
        capture(f2, u2);
        tests++;
        if (f2 !== 10'b1_0011_0010_0 || u2 != 0) begin
            fails++; $display("FAIL buf_frame2: got %b unstable=%0d, expected 1001100100 unstable=0", f2, u2);
        end
        count_lows(300, lows);
        tests++;
        if (lows != 0) begin fails++; $display("FAIL buf_b3_dropped: got %0d low cycles, expected 0", lows); end
    endtask

    task automatic test_flow_control();
        logic [7:0] d;
        logic [9:0] f;
        int         u, lows, waited;
        cts_n = 1'b1;
        repeat (3) tick();
        do_write(8'hC1);
        count_lows(1000, lows);
        read_reg(1'b0, d);
        tests++;
        if (lows != 0 || d !== 8'h80) begin
            fails++; $display("FAIL flow_held: got lows=%0d addr0=%h, expected 0 80", lows, d);
        end
        cts_n  = 1'b0;
        waited = -1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (uart_tx === 1'b0) begin
                waited = c;
                break;
            end
        end
        tests++;
        if (waited < 1) begin fails++; $display("FAIL flow_release: got no start in %0d cycles, expected start within 4", 4); end
        if (waited >= 1) begin
            capture(f, u);
            tests++;
            if (f !== 10'b1_0100_0001_0 || u != 0) begin
                fails++; $display("FAIL flow_frame: got %b unstable=%0d, expected 1010000010 unstable=0", f, u);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        int         lows;
        do_write(8'h55);
        tick();
        repeat (122 + 3 * 122 + 60) tick();
        rst = 1'b1;
        tick();
        read_reg(1'b1, d);
        tests++;
        if (uart_tx !== 1'b1 || d !== 8'h00) begin
            fails++; $display("FAIL midrst_next: got line=%b status=%h, expected 1 00", uart_tx, d);
        end
        rst = 1'b0;
        count_lows(400, lows);
        tests++;
        if (lows != 0) begin fails++; $display("FAIL midrst_no_resume: got %0d low cycles, expected 0", lows); end
        read_reg(1'b1, d);
        tests++;
        if (d !== 8'h04) begin fails++; $display("FAIL midrst_status: got %h, expected 04", d); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_crlf();
        test_back_to_back();
        test_flow_control();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
